// File: rtl/edge_mask_gen_if.sv
// Upstream edge-index handshake: an index transfers on a clock edge where
// edge_valid and edge_ready are both high; edge_ready never depends on edge_valid.
interface edge_mask_gen_if;
  logic        edge_valid;
  logic        edge_ready;
  logic [11:0] edge_idx;

  modport master (output edge_valid, output edge_idx, input edge_ready);
  modport slave  (input edge_valid, input edge_idx, output edge_ready);
endinterface

// File: rtl/edge_mask_gen.sv
// Edge-mask bus driver: FIFO-buffered 12-bit indices emitted as one-hot pulses on 8x512 lanes.
// Define EDGE_MASK_GEN_SWEEP_EN to compile in the range-sweep generator (SWEEP state).
module edge_mask_gen #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          en,
  edge_mask_gen_if.slave                edge_if,
  input  logic                          sweep_start,
  input  logic [11:0]                   sweep_lo,
  input  logic [11:0]                   sweep_hi,
  output logic [511:0]                  edge_mask_512p0,
  output logic [511:0]                  edge_mask_512p1,
  output logic [511:0]                  edge_mask_512p2,
  output logic [511:0]                  edge_mask_512p3,
  output logic [511:0]                  edge_mask_512p4,
  output logic [511:0]                  edge_mask_512p5,
  output logic [511:0]                  edge_mask_512p6,
  output logic [511:0]                  edge_mask_512p7,
  output logic                          busy,
  output logic                          sweep_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              emit_count,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_SWEEP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [11:0]     mem [FIFO_DEPTH];
  logic [4095:0]   mask_q, mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [11:0]     ptr_q, ptr_d, hi_q, hi_d;

  logic push, pop, sweep_emit, sweep_load, sweep_last, sweep_req, emit;
  logic [11:0] emit_idx;

`ifdef EDGE_MASK_GEN_SWEEP_EN
  assign sweep_req = sweep_start;
`else
  assign sweep_req = 1'b0;
  wire unused_sweep_start = sweep_start;
`endif

  assign edge_if.edge_ready = (level_q != FULL_LVL);
  assign push = edge_if.edge_valid && edge_if.edge_ready;

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Output decode: which action the current state takes this cycle
  always_comb begin
    pop        = 1'b0;
    sweep_emit = 1'b0;
    sweep_load = 1'b0;
    busy       = (state_q != S_IDLE);
`ifdef EDGE_MASK_GEN_SWEEP_EN
    sweep_busy = (state_q == S_SWEEP);
`else
    sweep_busy = 1'b0;
`endif
    case (state_q)
      S_IDLE:   sweep_load = sweep_req;
      S_STREAM: pop        = en;
      S_SWEEP:  sweep_emit = en;
      default:  pop        = 1'b0;
    endcase
  end

  assign sweep_last = sweep_emit && (ptr_q == hi_q);

  // Next-state logic; the FIFO occupancy after this edge decides STREAM vs IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_req)           state_d = S_SWEEP;
        else if (level_d != '0)  state_d = S_STREAM;
      end
      S_STREAM: if (level_d == '0) state_d = S_IDLE;
      S_SWEEP:  if (sweep_last)    state_d = (level_d != '0) ? S_STREAM : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    emit     = pop | sweep_emit;
    emit_idx = sweep_emit ? ptr_q : mem[rd_ptr_q];
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    mask_d   = emit ? (4096'(1) << emit_idx) : '0;
    count_d  = (emit && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    ptr_d    = sweep_load ? sweep_lo : (sweep_emit ? ptr_q + 12'd1 : ptr_q);
    hi_d     = sweep_load ? sweep_hi : hi_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      hi_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      hi_q     <= hi_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= edge_if.edge_idx;
  end

  assign edge_mask_512p0 = mask_q[511:0];
  assign edge_mask_512p1 = mask_q[1023:512];
  assign edge_mask_512p2 = mask_q[1535:1024];
  assign edge_mask_512p3 = mask_q[2047:1536];
  assign edge_mask_512p4 = mask_q[2559:2048];
  assign edge_mask_512p5 = mask_q[3071:2560];
  assign edge_mask_512p6 = mask_q[3583:3072];
  assign edge_mask_512p7 = mask_q[4095:3584];
  assign fifo_level      = level_q;
  assign emit_count      = count_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_edge_mask_gen.sv
// Self-checking bench for edge_mask_gen: queue-based reference model, per-cycle compare,
// directed scenarios plus randomized traffic. Sweep scenarios follow EDGE_MASK_GEN_SWEEP_EN.
module tb_edge_mask_gen;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef EDGE_MASK_GEN_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_n = 1'b1;
  logic en = 1'b0;
  logic sweep_start = 1'b0;
  logic [11:0] sweep_lo = '0, sweep_hi = '0;
  logic [511:0] m0, m1, m2, m3, m4, m5, m6, m7;
  logic busy, sweep_busy;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] emit_count;
  logic [1:0] state_dbg;
  wire [4095:0] mask_all = {m7, m6, m5, m4, m3, m2, m1, m0};

  edge_mask_gen_if eif();

  edge_mask_gen #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .en(en), .edge_if(eif),
    .sweep_start(sweep_start), .sweep_lo(sweep_lo), .sweep_hi(sweep_hi),
    .edge_mask_512p0(m0), .edge_mask_512p1(m1), .edge_mask_512p2(m2), .edge_mask_512p3(m3),
    .edge_mask_512p4(m4), .edge_mask_512p5(m5), .edge_mask_512p6(m6), .edge_mask_512p7(m7),
    .busy(busy), .sweep_busy(sweep_busy), .fifo_level(fifo_level),
    .emit_count(emit_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: pending indices and pending sweep indices as plain queues
  logic [11:0] fifo_m[$];
  logic [11:0] sweep_m[$];
  logic        exp_valid = 1'b0;
  logic [11:0] exp_idx = '0;
  int unsigned exp_cnt = 0;

  always @(posedge CLK or negedge RST_n) begin
    bit ready, push, idle;
    int n;
    if (!RST_n) begin
      fifo_m.delete();
      sweep_m.delete();
      exp_valid = 1'b0;
      exp_cnt   = 0;
    end else begin
      ready = (fifo_m.size() < DEPTH);
      push  = eif.edge_valid && ready;
      idle  = (fifo_m.size() == 0) && (sweep_m.size() == 0);
      exp_valid = 1'b0;
      if (SWEEP && idle && sweep_start) begin
        n = int'(12'(sweep_hi - sweep_lo)) + 1;
        for (int i = 0; i < n; i++) sweep_m.push_back(12'(sweep_lo + 12'(i)));
      end else if (en && sweep_m.size() > 0) begin
        exp_idx = sweep_m.pop_front();
        exp_valid = 1'b1;
      end else if (en && fifo_m.size() > 0) begin
        exp_idx = fifo_m.pop_front();
        exp_valid = 1'b1;
      end
      if (push) fifo_m.push_back(eif.edge_idx);
      if (exp_valid && exp_cnt != (2**CNT_W - 1)) exp_cnt++;
    end
  end

  // compare process: every registered output, every cycle
  always @(negedge CLK) begin
    logic [4095:0] em;
    em = exp_valid ? (4096'(1) << exp_idx) : '0;
    n_vec++;
    if (mask_all !== em) begin
      n_err++;
      $display("FAIL mask: got %0d bits set (expected bit set=%0d), required valid=%0d idx=%h (t=%0t)",
               $countones(mask_all), mask_all[exp_idx], exp_valid, exp_idx, $time);
    end
    chk("edge_ready", 32'(eif.edge_ready), 32'(fifo_m.size() < DEPTH));
    chk("fifo_level", 32'(fifo_level), 32'(fifo_m.size()));
    chk("busy", 32'(busy), 32'(fifo_m.size() > 0 || sweep_m.size() > 0));
    chk("sweep_busy", 32'(sweep_busy), 32'(sweep_m.size() > 0));
    chk("emit_count", 32'(emit_count), exp_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_sweep(input logic [11:0] lo, input logic [11:0] hi);
    sweep_lo = lo; sweep_hi = hi; sweep_start = 1'b1;
    cyc(1);
    sweep_start = 1'b0;
  endtask

  initial begin
    int cnt;
    eif.edge_valid = 1'b0;
    eif.edge_idx   = '0;
    #1 RST_n = 1'b0;
    cyc(3);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(eif.edge_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(emit_count), 0);
    chk("rst_mask_ones", $countones(mask_all), 0);
    RST_n = 1'b1;
    en = 1'b1;

    // first-pulse latency and lane corners
    cyc(1);
    eif.edge_valid = 1'b1; eif.edge_idx = 12'h000;
    cyc(1);
    chk("lat_t1_zero", $countones(mask_all), 0);
    eif.edge_idx = 12'hFFF;
    cyc(1);
    eif.edge_valid = 1'b0;
    chk("lat_p0_0", 32'(m0[0]), 1);
    chk("lat_ones_a", $countones(mask_all), 1);
    cyc(1);
    chk("lat_p7_511", 32'(m7[511]), 1);
    chk("lat_ones_b", $countones(mask_all), 1);
    chk("lat_count2", 32'(emit_count), 2);
    cyc(2);

    // fill with en low, then drain in order
    en = 1'b0;
    eif.edge_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      eif.edge_idx = 12'($urandom_range(0, 4095));
      cyc(1);
    end
    eif.edge_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 8);
    chk("full_ready", 32'(eif.edge_ready), 0);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if ($countones(mask_all) == 1) cnt++;
    end
    chk("drain_pulses", cnt, 8);
    cyc(1);
    chk("drain_done_busy", 32'(busy), 0);

`ifdef EDGE_MASK_GEN_SWEEP_EN
    // sweep across the p0/p1 lane boundary
    pulse_sweep(12'h1FE, 12'h201);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (sweep_busy) cnt++;
      if (i == 1) chk("sw_p0_510", 32'(m0[510]), 1);
      if (i == 4) chk("sw_p1_1", 32'(m1[1]), 1);
      cyc(1);
    end
    chk("sw_busy_cycles", cnt, 4);

    // wrapping sweep with a push arriving mid-sweep
    pulse_sweep(12'hFFF, 12'h000);
    eif.edge_valid = 1'b1; eif.edge_idx = 12'h123;
    cyc(1);
    eif.edge_valid = 1'b0;
    chk("wrap_p7_511", 32'(m7[511]), 1);
    cyc(1);
    chk("wrap_p0_0", 32'(m0[0]), 1);
    cyc(1);
    chk("wrap_p0_291", 32'(m0[291]), 1);
    cyc(2);

    // reset in the middle of a sweep with three queued indices
    pulse_sweep(12'h000, 12'h0C8);
`else
    pulse_sweep(12'h010, 12'h020);
    chk("nosweep_busy", 32'(busy), 0);
    chk("nosweep_sbusy", 32'(sweep_busy), 0);
    cyc(1);
    chk("nosweep_mask", $countones(mask_all), 0);
    en = 1'b0;
`endif
    eif.edge_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eif.edge_idx = 12'($urandom_range(0, 4095));
      cyc(1);
    end
    eif.edge_valid = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 3);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_ready", 32'(eif.edge_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sbusy", 32'(sweep_busy), 0);
    chk("arst_count", 32'(emit_count), 0);
    chk("arst_mask", $countones(mask_all), 0);
    cyc(2);
    RST_n = 1'b1;
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      cnt += $countones(mask_all);
    end
    chk("post_rst_pulses", cnt, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en             = ($urandom_range(0, 3) != 0);
      eif.edge_valid = $urandom_range(0, 1);
      eif.edge_idx   = 12'($urandom_range(0, 4095));
      sweep_start    = ($urandom_range(0, 40) == 0);
      sweep_lo       = 12'($urandom_range(0, 4095));
      sweep_hi       = 12'(sweep_lo + 12'($urandom_range(0, 20)));
      cyc(1);
    end
    eif.edge_valid = 1'b0; sweep_start = 1'b0; en = 1'b1;
    cyc(40);

    // sustained streaming to saturate the pulse counter
    eif.edge_valid = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      eif.edge_idx = 12'($urandom_range(0, 4095));
      cyc(1);
    end
    eif.edge_valid = 1'b0;
    cyc(12);
    chk("count_saturated", 32'(emit_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/edge_mask_gen.md
# edge_mask_gen

Transmit-side driver for the parameter-check edge-mask bus. Accepts a stream of 12-bit edge indices through a valid/ready handshake and buffers them in a small FIFO. Emits each index as a one-cycle one-hot pulse on the eight 512-bit `edge_mask_512p*` lanes that feed the sticky edge accumulator. It also provides a range-sweep generator for self-test and bring-up.

## Interface
- `FIFO_DEPTH`, 8: index FIFO depth. Must be a power of two, 2..64.
- `CNT_W`, 16: width of `emit_count`.

- `CLK` in 1: single clock, rising edge.
- `RST_n` in 1: reset, asynchronous, active-low.
- `en` in 1: emission enable. When low, no FIFO pop and no sweep advance; masks stay zero.
- `edge_valid` in 1: upstream index valid.
- `edge_ready` out 1: `!fifo_full`, registered state only. No combinational path from `edge_valid`.
- `edge_idx` in 12: edge index. Lane = `idx[11:9]`, bit within lane = `idx[8:0]`.
- `sweep_start` in 1: one-cycle request to start a sweep.
- `sweep_lo`, `sweep_hi` in 12 each: inclusive sweep bounds, sampled on an accepted `sweep_start`.
- `edge_mask_512p0` … `edge_mask_512p7` out 512 each: registered mask lanes. `p0` carries indices 0..511, `p7` carries 3584..4095.
- `busy` out 1: state is not IDLE.
- `sweep_busy` out 1: state is SWEEP.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `emit_count` out CNT_W: pulses emitted since reset. Saturates at all-ones.

## Operation
- FIFO push on `edge_valid && edge_ready`. When full, `edge_ready` = 0 even if a pop occurs in the same cycle.
- States:
  - IDLE: FIFO empty, no sweep.
  - STREAM: FIFO non-empty.
  - SWEEP: walking the sweep range.
- Transitions:
  - IDLE→SWEEP on `sweep_start`, when the SWEEP feature is compiled in.
  - IDLE→STREAM when the FIFO becomes non-empty.
  - STREAM→IDLE after the pop that empties the FIFO.
  - SWEEP→STREAM or SWEEP→IDLE after the final sweep index, depending on FIFO occupancy.
- `sweep_start` is accepted only in IDLE. If it coincides with a push in IDLE, the sweep wins and the pushed index waits in the FIFO.
- STREAM: with `en`=1, pop one index per cycle and emit it.
- SWEEP:
  - With `en`=1, emit the current pointer each cycle. The pointer starts at `sweep_lo`, increments mod 4096 and stops after emitting `sweep_hi`.
  - `lo>hi` wraps through 4095→0. `lo==hi` emits one pulse.
  - Pushes continue into the FIFO. Nothing is popped until the sweep ends.
- Emission: in the cycle after an emit decision, exactly one bit of the 4096-bit concatenation `{p7..p0}` is 1. All other lanes are zero.
- Non-emitting cycles drive all 4096 bits to 0. Duplicate indices are emitted as separate pulses (the downstream accumulator is idempotent).
- `emit_count` increments by 1 per emitted pulse and holds at `2^CNT_W-1`.

## Timing
- Reset values:
  - masks all 0
  - `edge_ready` 1
  - `busy` 0
  - `sweep_busy` 0
  - `fifo_level` 0
  - `emit_count` 0
  - state IDLE
  - FIFO pointers 0
- Latency: an index accepted at edge t into an empty FIFO with `en`=1 appears on the mask lanes during cycle t+2. The pop occurs at t+1 and the output register loads it.
- Throughput: one pulse per cycle, sustained.
- Each pulse lasts exactly one cycle.
- `en` deasserted mid-stream or mid-sweep: the next cycle's masks are zero and state/pointers hold. Emission resumes at the held position when `en` returns.
- Asynchronous reset mid-operation: immediate return to reset values. FIFO contents are discarded and any sweep is abandoned.
- Simultaneous push and pop when not full: `fifo_level` unchanged.

## Configuration
- `EDGE_MASK_GEN_SWEEP_EN` defined: SWEEP state, sweep pointer and `sweep_*` inputs are active.
- Not defined:
  - `sweep_start`, `sweep_lo` and `sweep_hi` are ignored.
  - `sweep_busy` is tied to 0.
  - The state machine has only IDLE and STREAM. All other behaviour is unchanged.

## Test plan
- Reset release, push idx 0x000, then 0xFFF, with `en`=1 -> `p0[0]`=1 in cycle t+2, then `p7[511]`=1 the next cycle. All other bits are 0. `emit_count`=2.
- `en`=0, push 9 indices with FIFO_DEPTH=8 -> `edge_ready` drops after the 8th; `fifo_level`=8. Raise `en` -> 8 pulses in consecutive cycles, in order.
- Sweep lo=0x1FE, hi=0x201 -> pulses on `p0[510]`, `p0[511]`, `p1[0]`, `p1[1]`; `sweep_busy` high for 4 cycles.
- Sweep lo=0xFFF, hi=0x000 with a push of 0x123 during the sweep -> pulses `p7[511]`, `p0[0]`, then `p0[291]`.
- Assert `RST_n`=0 mid-sweep with FIFO level 3 -> all outputs return to reset values immediately. No pulse occurs after release.
- Drive 65540 pulses with `CNT_W`=16 -> `emit_count` holds at 0xFFFF.
